// File: rtl/deser_pkg.sv
// Shared types and length defaults for the packet deserializer.
package deser_pkg;

    typedef enum logic [1:0] {
        SEL_COND  = 2'b00,
        SEL_TRIV  = 2'b01,
        SEL_DRBG  = 2'b10,
        SEL_SPARE = 2'b11
    } sel_e;

    localparam int unsigned LEN_COND_DEF = 384;
    localparam int unsigned LEN_TRIV_DEF = 160;

    function automatic int unsigned len_of(input sel_e sel,
                                           input int unsigned len0,
                                           input int unsigned len1,
                                           input int unsigned len2,
                                           input int unsigned len3);
        int unsigned len;
        case (sel)
            SEL_COND: len = len0;
            SEL_TRIV: len = len1;
            SEL_DRBG: len = len2;
            default:  len = len3;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage, full/empty flags and flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of 2 and at least 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO succeeds only when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/deser_pkt.sv
// Serial-to-parallel packet deserializer with per-packet length select,
// selectable bit order and an output FIFO with overflow accounting.
module deser_pkt
    import deser_pkg::*;
#(
    parameter int unsigned MAX_W     = LEN_COND_DEF,
    parameter int unsigned LEN0      = LEN_COND_DEF,
    parameter int unsigned LEN1      = LEN_TRIV_DEF,
    parameter int unsigned LEN2      = LEN_COND_DEF,
    parameter int unsigned LEN3      = 256,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned DEPTH     = 2,
    localparam int unsigned CNT_W    = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic [1:0]       sel,
    input  logic             flush,
    input  logic             clr_ovf,
    output logic [MAX_W-1:0] out_data,
    output logic [CNT_W-1:0] out_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf_sticky,
    output logic [7:0]       drop_cnt
);

    if (LEN0 < 1 || LEN0 > MAX_W || LEN1 < 1 || LEN1 > MAX_W ||
        LEN2 < 1 || LEN2 > MAX_W || LEN3 < 1 || LEN3 > MAX_W) begin : g_len_check
        $error("deser_pkt: every LENx must be in 1..MAX_W");
    end

    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       cur_len;
    logic [MAX_W-1:0]       asm_q;
    logic [MAX_W-1:0]       base;
    logic [MAX_W-1:0]       word;
    logic                   complete;
    logic                   pop_ok;
    logic                   push;
    logic                   drop;
    logic                   full;
    logic                   empty;
    logic [MAX_W+CNT_W-1:0] head;

    // The first bit of a packet uses the live sel and a cleared register.
    always_comb begin
        cur_len = (bit_cnt == '0) ? CNT_W'(len_of(sel_e'(sel), LEN0, LEN1, LEN2, LEN3)) : len_q;
        base    = (bit_cnt == '0) ? '0 : asm_q;
        word    = base;
        if (MSB_FIRST) begin
            word    = base << 1;
            word[0] = serial_in;
        end else begin
            word[bit_cnt] = serial_in;
        end
    end

    assign complete = bit_valid && !flush && (bit_cnt == cur_len - CNT_W'(1));
    assign pop_ok   = out_valid && out_ready;
    assign push     = complete && (!full || pop_ok);
    assign drop     = complete && full && !pop_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            len_q      <= '0;
            asm_q      <= '0;
            ovf_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (flush) begin
                bit_cnt <= '0;
                asm_q   <= '0;
            end else if (bit_valid) begin
                if (bit_cnt == '0) begin
                    len_q <= cur_len;
                end
                asm_q   <= word;
                bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
            end

            if (drop) begin
                ovf_sticky <= 1'b1;
                drop_cnt   <= clr_ovf ? 8'd1 :
                              (drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1;
            end else if (clr_ovf) begin
                ovf_sticky <= 1'b0;
                drop_cnt   <= '0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (MAX_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data ({cur_len, word}),
        .pop       (out_ready && !flush),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid = !empty;
    assign out_data  = head[MAX_W-1:0];
    assign out_len   = head[MAX_W +: CNT_W];
    assign busy      = (bit_cnt != '0);

endmodule

// File: tb/tb_deser_pkt.sv
// Directed bench for deser_pkt: an MSB-first and an LSB-first instance share stimulus.
module tb_deser_pkt;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         serial_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic [1:0]   sel = 2'b00;
    logic         flush = 1'b0;
    logic         clr_ovf = 1'b0;
    logic         out_ready = 1'b0;

    logic [383:0] data_m, data_l;
    logic [8:0]   len_m, len_l;
    logic         valid_m, valid_l, busy_m, busy_l, ovf_m, ovf_l;
    logic [7:0]   drop_m, drop_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    deser_pkt u_msb (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_valid(bit_valid),
        .sel(sel), .flush(flush), .clr_ovf(clr_ovf), .out_data(data_m),
        .out_len(len_m), .out_valid(valid_m), .out_ready(out_ready),
        .busy(busy_m), .ovf_sticky(ovf_m), .drop_cnt(drop_m)
    );

    deser_pkt #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_valid(bit_valid),
        .sel(sel), .flush(flush), .clr_ovf(clr_ovf), .out_data(data_l),
        .out_len(len_l), .out_valid(valid_l), .out_ready(out_ready),
        .busy(busy_l), .ovf_sticky(ovf_l), .drop_cnt(drop_l)
    );

    typedef struct {
        logic [1:0]   sel;
        int           pat;
        int           n;
        logic [383:0] exp_m;
        logic [383:0] exp_l;
    } vec_t;

    vec_t vecs[6];

    localparam logic [383:0] PA   = {224'h0, {40{4'hA}}};
    localparam logic [383:0] PB   = {224'h0, 1'b1, 159'h0};
    localparam logic [383:0] PC   = {224'h0, {160{1'b1}}};
    localparam logic [383:0] P5   = {224'h0, {40{4'h5}}};
    localparam logic [383:0] TOP  = {1'b1, 383'h0};
    localparam logic [383:0] ONE  = 384'h1;
    localparam logic [383:0] ON256 = {128'h0, {256{1'b1}}};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkd(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // pat 0: alternating starting with 1; 1: only first bit; 2: all ones; 3: only last bit
    function automatic logic bit_of(input int pat, input int i, input int n);
        case (pat)
            0:       return (i % 2) == 0;
            1:       return i == 0;
            2:       return 1'b1;
            default: return i == n - 1;
        endcase
    endfunction

    task automatic send(input logic [1:0] s, input int pat, input int n,
                        input int flip_at, input logic [1:0] s2, input bit gap,
                        input bit rdy_last, input bit clr_last, input bit lat);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                bit_valid = 1'b0;
                tick();
            end
            sel       = (i >= flip_at) ? s2 : s;
            serial_in = bit_of(pat, i, n);
            bit_valid = 1'b1;
            if (i == n - 1) begin
                out_ready = rdy_last;
                clr_ovf   = clr_last;
                if (lat) chkb("valid_before_last_edge", valid_m, 1'b0);
            end
            tick();
        end
        bit_valid = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        if (lat) chkb("valid_after_last_edge", valid_m, 1'b1);
    endtask

    task automatic pkt(input logic [1:0] s, input int pat, input int n);
        send(s, pat, n, n, s, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic partial(input logic [1:0] s, input int k);
        for (int i = 0; i < k; i++) begin
            sel       = s;
            serial_in = i[0];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chkd({tag, "_data_m"}, data_m, '0);
        chkd({tag, "_data_l"}, data_l, '0);
        chkn({tag, "_len_m"}, int'(len_m), 0);
        chkn({tag, "_len_l"}, int'(len_l), 0);
        chkb({tag, "_valid"}, valid_m, 1'b0);
        chkb({tag, "_busy"}, busy_m, 1'b0);
        chkb({tag, "_ovf"}, ovf_m, 1'b0);
        chkn({tag, "_drop"}, int'(drop_m), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b01, 0, 160, PA, P5};
        vecs[1] = '{2'b00, 1, 384, TOP, ONE};
        vecs[2] = '{2'b11, 2, 256, ON256, ON256};
        vecs[3] = '{2'b10, 3, 384, ONE, TOP};
        vecs[4] = '{2'b01, 1, 160, PB, 384'h1};
        vecs[5] = '{2'b11, 0, 256, {128'h0, {64{4'hA}}}, {128'h0, {64{4'h5}}}};

        tick();
        tick();
        rst_n = 1'b1;
        chk_zero("reset");

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].sel, vecs[v].pat, vecs[v].n, vecs[v].n, vecs[v].sel,
                 1'b0, 1'b0, 1'b0, 1'b1);
            chkd($sformatf("vec%0d_data_msb", v), data_m, vecs[v].exp_m);
            chkd($sformatf("vec%0d_data_lsb", v), data_l, vecs[v].exp_l);
            chkn($sformatf("vec%0d_len_msb", v), int'(len_m), vecs[v].n);
            chkn($sformatf("vec%0d_len_lsb", v), int'(len_l), vecs[v].n);
            chkb($sformatf("vec%0d_busy", v), busy_m, 1'b0);
            pop();
            chkb($sformatf("vec%0d_valid_after_pop", v), valid_m, 1'b0);
        end

        // Overflow with the consumer stalled: third packet is dropped.
        pkt(2'b01, 0, 160);
        pkt(2'b01, 1, 160);
        chkb("ovf_before_drop", ovf_m, 1'b0);
        pkt(2'b01, 2, 160);
        chkb("ovf_sticky", ovf_m, 1'b1);
        chkn("ovf_drop_cnt", int'(drop_m), 1);
        chkd("ovf_head0", data_m, PA);
        pop();
        chkd("ovf_head1", data_m, PB);
        chkn("ovf_head1_len", int'(len_m), 160);
        pop();
        chkb("ovf_empty", valid_m, 1'b0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chkb("clr_ovf_sticky", ovf_m, 1'b0);
        chkn("clr_drop_cnt", int'(drop_m), 0);

        // Completion into a full FIFO while the head is popped: no drop.
        pkt(2'b01, 0, 160);
        pkt(2'b01, 1, 160);
        send(2'b01, 2, 160, 160, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        chkn("simul_drop_cnt", int'(drop_m), 0);
        chkb("simul_ovf", ovf_m, 1'b0);
        chkd("simul_head", data_m, PB);
        pop();
        chkd("simul_tail", data_m, PC);
        pop();
        chkb("simul_empty", valid_m, 1'b0);

        // Drop in the same cycle as clr_ovf: the drop wins.
        pkt(2'b01, 0, 160);
        pkt(2'b01, 0, 160);
        pkt(2'b01, 0, 160);
        chkn("pre_clr_drop_cnt", int'(drop_m), 1);
        send(2'b01, 0, 160, 160, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        chkn("clr_vs_drop_cnt", int'(drop_m), 1);
        chkb("clr_vs_drop_ovf", ovf_m, 1'b1);
        pop();
        chkb("one_queued", valid_m, 1'b1);

        // Flush mid-packet with one packet queued.
        partial(2'b00, 100);
        chkb("busy_mid_packet", busy_m, 1'b1);
        flush     = 1'b1;
        bit_valid = 1'b1;
        serial_in = 1'b1;
        tick();
        flush     = 1'b0;
        bit_valid = 1'b0;
        chkb("flush_valid", valid_m, 1'b0);
        chkb("flush_busy", busy_m, 1'b0);
        chkb("flush_keeps_ovf", ovf_m, 1'b1);
        chkn("flush_keeps_drop", int'(drop_m), 1);
        send(2'b00, 1, 384, 384, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chkd("post_flush_msb", data_m, TOP);
        chkd("post_flush_lsb", data_l, ONE);
        chkn("post_flush_len", int'(len_m), 384);
        pop();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // Gapped packet with sel changed after the start.
        send(2'b01, 0, 160, 50, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        chkn("gap_len", int'(len_m), 160);
        chkd("gap_data_msb", data_m, PA);
        chkd("gap_data_lsb", data_l, P5);
        pop();

        // Reset mid-packet with a full FIFO and a recorded drop.
        pkt(2'b01, 0, 160);
        pkt(2'b01, 1, 160);
        pkt(2'b01, 2, 160);
        partial(2'b01, 50);
        chkb("pre_reset_busy", busy_m, 1'b1);
        chkb("pre_reset_ovf", ovf_m, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_zero("midrst");
        rst_n = 1'b1;
        send(2'b11, 2, 256, 256, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        chkd("post_rst_msb", data_m, ON256);
        chkd("post_rst_lsb", data_l, ON256);
        chkn("post_rst_len", int'(len_m), 256);
        pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
